// File: rtl/maze_navigator.sv
// Grid maze player: validates direction pulses against a wall map, tracks strikes and moves,
// and enforces a lockout gap between evaluated moves.
module maze_navigator #(
  parameter int unsigned COLS        = 18,
  parameter int unsigned ROWS        = 11,
  parameter int unsigned MAX_STRIKES = 3,
  parameter int unsigned GAP_CYCLES  = 10_000_000,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 pause_i,
  input  logic                 up_i,
  input  logic                 down_i,
  input  logic                 left_i,
  input  logic                 right_i,
  input  logic [COLS*ROWS-1:0] wall_map_i,
  input  logic [RW-1:0]        start_row_i,
  input  logic [CW-1:0]        start_col_i,
  input  logic [RW-1:0]        goal_row_i,
  input  logic [CW-1:0]        goal_col_i,
  output logic [RW-1:0]        pos_row_o,
  output logic [CW-1:0]        pos_col_o,
  output logic [2:0]           state_o,
  output logic                 bump_o,
  output logic [3:0]           strikes_o,
  output logic [15:0]          move_count_o
);

  localparam int unsigned IW = $clog2(COLS * ROWS);
  localparam int unsigned LW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LW-1:0] LockLoad = LW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RowMax   = RW'(ROWS - 1);
  localparam logic [CW-1:0] ColMax   = CW'(COLS - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPlay   = 3'd1,
    StPaused = 3'd2,
    StWon    = 3'd3,
    StFail   = 3'd4
  } state_e;

  // Assert asynchronously, release on a clock edge so the first active edge is clean.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  state_e        state_q, state_d;
  logic [RW-1:0] pos_row_q, pos_row_d;
  logic [CW-1:0] pos_col_q, pos_col_d;
  logic          bump_q, bump_d;
  logic [3:0]    strikes_q, strikes_d;
  logic [15:0]   move_count_q, move_count_d;
  logic [LW-1:0] lock_q, lock_d;

  logic [RW-1:0] start_row_c, goal_row_c, tgt_row;
  logic [CW-1:0] start_col_c, goal_col_c, tgt_col;
  logic [IW-1:0] tgt_idx;
  logic          move_req, off_grid, legal;

  assign start_row_c = (start_row_i > RowMax) ? RowMax : start_row_i;
  assign start_col_c = (start_col_i > ColMax) ? ColMax : start_col_i;
  assign goal_row_c  = (goal_row_i > RowMax) ? RowMax : goal_row_i;
  assign goal_col_c  = (goal_col_i > ColMax) ? ColMax : goal_col_i;

  // Priority up > down > left > right; lower-priority pulses are simply not looked at.
  always_comb begin
    tgt_row  = pos_row_q;
    tgt_col  = pos_col_q;
    off_grid = 1'b0;
    move_req = up_i | down_i | left_i | right_i;
    if (up_i) begin
      off_grid = (pos_row_q == '0);
      tgt_row  = pos_row_q - RW'(1);
    end else if (down_i) begin
      off_grid = (pos_row_q == RowMax);
      tgt_row  = pos_row_q + RW'(1);
    end else if (left_i) begin
      off_grid = (pos_col_q == '0);
      tgt_col  = pos_col_q - CW'(1);
    end else if (right_i) begin
      off_grid = (pos_col_q == ColMax);
      tgt_col  = pos_col_q + CW'(1);
    end
    tgt_idx = IW'(tgt_row) * IW'(COLS) + IW'(tgt_col);
    legal   = !off_grid && wall_map_i[tgt_idx];
  end

  always_comb begin
    state_d      = state_q;
    pos_row_d    = pos_row_q;
    pos_col_d    = pos_col_q;
    bump_d       = 1'b0;
    strikes_d    = strikes_q;
    move_count_d = move_count_q;
    lock_d       = lock_q;
    if (start_i) begin
      pos_row_d    = start_row_c;
      pos_col_d    = start_col_c;
      strikes_d    = '0;
      move_count_d = '0;
      lock_d       = '0;
      state_d      = (start_row_c == goal_row_c && start_col_c == goal_col_c) ? StWon : StPlay;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (pause_i) begin
            state_d = StPaused;
          end else if (lock_q != '0) begin
            lock_d = lock_q - LW'(1);
          end else if (move_req) begin
            lock_d = LockLoad;
            if (legal) begin
              pos_row_d = tgt_row;
              pos_col_d = tgt_col;
              if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
              if (tgt_row == goal_row_c && tgt_col == goal_col_c) state_d = StWon;
            end else begin
              bump_d    = 1'b1;
              strikes_d = strikes_q + 4'd1;
              if (strikes_d == 4'(MAX_STRIKES)) state_d = StFail;
            end
          end
        end
        StPaused: if (!pause_i) state_d = StPlay;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= StIdle;
      pos_row_q    <= '0;
      pos_col_q    <= '0;
      bump_q       <= 1'b0;
      strikes_q    <= '0;
      move_count_q <= '0;
      lock_q       <= '0;
    end else begin
      state_q      <= state_d;
      pos_row_q    <= pos_row_d;
      pos_col_q    <= pos_col_d;
      bump_q       <= bump_d;
      strikes_q    <= strikes_d;
      move_count_q <= move_count_d;
      lock_q       <= lock_d;
    end
  end

  assign state_o      = state_q;
  assign pos_row_o    = pos_row_q;
  assign pos_col_o    = pos_col_q;
  assign bump_o       = bump_q;
  assign strikes_o    = strikes_q;
  assign move_count_o = move_count_q;

endmodule
